// File: rtl/bcd_count_pkg.sv
// Shared encodings for the two-digit BCD count sequencer.
package bcd_count_pkg;

    // Sequencer states; values are fixed so debug probes read consistently.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Largest legal value of one BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit incrementer/decrementer with ripple carry/borrow.
module bcd_digit_step
    import bcd_count_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       up_i,
    input  logic       carry_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    // Step the digit only when a carry/borrow arrives; wrap inside 0..9.
    always_comb begin
        digit_o = digit_i;
        carry_o = 1'b0;
        if (carry_i) begin
            if (up_i) begin
                if (digit_i >= BCD_MAX) begin
                    digit_o = 4'd0;
                    carry_o = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == 4'd0) begin
                    digit_o = BCD_MAX;
                    carry_o = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Two-digit BCD counter arbitrating manual up/down requests against an
// auto-step timer, with a holdoff that pauses auto-stepping after manual use.
module bcd_count_sequencer
    import bcd_count_pkg::*;
#(
    parameter int unsigned TICK_PERIOD   = 500000,
    parameter int unsigned HOLDOFF_TICKS = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Auto_En,
    input  logic       i_Auto_Dir,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic       o_Step,
    output logic       o_Wrap,
    output logic       o_Auto_Active,
    output logic       o_LED_Toggle
);

    localparam int unsigned      HO_W         = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [CNT_W-1:0] TICK_LAST    = CNT_W'(TICK_PERIOD - 1);
    localparam logic [HO_W-1:0]  HOLDOFF_LOAD = HO_W'(HOLDOFF_TICKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [HO_W-1:0]  holdoff_q, holdoff_d;
    logic [3:0]       tens_q, ones_q;
    logic             step_q, wrap_q, led_q;

    logic             tick;
    logic             manual_req;
    logic             auto_step;
    logic             step_en;
    logic             step_up;
    logic [3:0]       ones_next, tens_next;
    logic             ones_carry, tens_carry;

    // Up and Down together cancel and also suppress a coincident auto tick.
    assign tick       = (timer_q == TICK_LAST);
    assign manual_req = i_Up ^ i_Down;
    assign auto_step  = tick && (state_q == S_RUN) && !i_Up && !i_Down;
    assign step_en    = manual_req || auto_step;
    assign step_up    = manual_req ? i_Up : i_Auto_Dir;

    bcd_digit_step u_ones (
        .digit_i (ones_q),
        .up_i    (step_up),
        .carry_i (step_en),
        .digit_o (ones_next),
        .carry_o (ones_carry)
    );

    bcd_digit_step u_tens (
        .digit_i (tens_q),
        .up_i    (step_up),
        .carry_i (ones_carry),
        .digit_o (tens_next),
        .carry_o (tens_carry)
    );

    // Timer restarts on manual steps so the next auto step is a full period away.
    always_comb begin
        timer_d = timer_q + CNT_W'(1);
        if (state_q == S_IDLE || manual_req || tick) begin
            timer_d = '0;
        end
    end

    // Next-state and holdoff bookkeeping.
    always_comb begin
        state_d   = state_q;
        holdoff_d = holdoff_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_Auto_En) begin
                    state_d = (holdoff_q == '0) ? S_RUN : S_HOLD;
                end
            end
            S_RUN: begin
                if (!i_Auto_En) begin
                    state_d = S_IDLE;
                end else if (manual_req) begin
                    holdoff_d = HOLDOFF_LOAD;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!i_Auto_En) begin
                    state_d   = S_IDLE;
                    holdoff_d = '0;
                end else if (manual_req) begin
                    holdoff_d = HOLDOFF_LOAD;
                end else if (holdoff_q == '0) begin
                    state_d = S_RUN;
                end else if (tick) begin
                    holdoff_d = holdoff_q - HO_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                holdoff_d = '0;
            end
        endcase
    end

    // State, timer, count and pulse registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            holdoff_q <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            step_q    <= 1'b0;
            wrap_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            holdoff_q <= holdoff_d;
            tens_q    <= tens_next;
            ones_q    <= ones_next;
            step_q    <= step_en;
            wrap_q    <= tens_carry;
            if (manual_req) begin
                led_q <= ~led_q;
            end
        end
    end

    assign o_Tens        = tens_q;
    assign o_Ones        = ones_q;
    assign o_Step        = step_q;
    assign o_Wrap        = wrap_q;
    assign o_LED_Toggle  = led_q;
    assign o_Auto_Active = (state_q == S_RUN);

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench with a step scoreboard for bcd_count_sequencer.
module tb_bcd_count_sequencer;

    logic       clk = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_Up = 1'b0;
    logic       i_Down = 1'b0;
    logic       i_Auto_En = 1'b0;
    logic       i_Auto_Dir = 1'b0;
    logic [3:0] o_Tens, o_Ones;
    logic       o_Step, o_Wrap, o_Auto_Active, o_LED_Toggle;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   step_cycs[$];
    int   step_count = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_val = 0;
    logic exp_led = 1'b0;

    bcd_count_sequencer #(
        .TICK_PERIOD   (8),
        .HOLDOFF_TICKS (2),
        .CNT_W         (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (i_Rst_L),
        .i_Up          (i_Up),
        .i_Down        (i_Down),
        .i_Auto_En     (i_Auto_En),
        .i_Auto_Dir    (i_Auto_Dir),
        .o_Tens        (o_Tens),
        .o_Ones        (o_Ones),
        .o_Step        (o_Step),
        .o_Wrap        (o_Wrap),
        .o_Auto_Active (o_Auto_Active),
        .o_LED_Toggle  (o_LED_Toggle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every o_Step pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_Step === 1'b1) begin
            exp_t e;
            step_count++;
            step_cycs.push_back(cyc);
            check("step_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("step_value", 32'({o_Tens, o_Ones, o_Wrap}),
                      32'({e.tens, e.ones, e.wrap}));
            end
        end else begin
            check("wrap_without_step", 32'(o_Wrap), 32'd0);
        end
    end

    function automatic int step_cyc_at(input int idx);
        if (idx < step_cycs.size()) return step_cycs[idx];
        return -1;
    endfunction

    // Queue the expected result of one step in the given direction.
    task automatic push_step(input bit up);
        exp_t e;
        bit   w;
        if (up) begin
            w       = (exp_val == 99);
            exp_val = (exp_val + 1) % 100;
        end else begin
            w       = (exp_val == 0);
            exp_val = (exp_val + 99) % 100;
        end
        e.tens = 4'(exp_val / 10);
        e.ones = 4'(exp_val % 10);
        e.wrap = w;
        sb.push_back(e);
    endtask

    // Hold the request across one rising edge, then leave a gap cycle.
    task automatic pulse(input logic up, input logic dn);
        i_Up   = up;
        i_Down = dn;
        @(posedge clk); #2;
        i_Up   = 1'b0;
        i_Down = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic man(input bit up);
        push_step(up);
        exp_led = ~exp_led;
        pulse(up, !up);
    endtask

    task automatic wait_steps(input int n, input int budget);
        int k = 0;
        while (step_count < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("step_timeout", 32'(step_count >= n), 32'd1);
    endtask

    task automatic do_reset();
        i_Rst_L = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        i_Rst_L = 1'b1;
        exp_val = 0;
        exp_led = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        int sc;
        #1;
        do_reset();

        // Reset state
        check("rst_tens", 32'(o_Tens), 32'd0);
        check("rst_ones", 32'(o_Ones), 32'd0);
        check("rst_step", 32'(o_Step), 32'd0);
        check("rst_wrap", 32'(o_Wrap), 32'd0);
        check("rst_led", 32'(o_LED_Toggle), 32'd0);
        check("rst_auto", 32'(o_Auto_Active), 32'd0);

        // Ten manual increments from 00
        sc = step_count;
        for (int i = 0; i < 10; i++) man(1'b1);
        wait_steps(sc + 10, 20);
        check("up10_steps", 32'(step_count - sc), 32'd10);
        check("up10_count", 32'({o_Tens, o_Ones}), 32'h10);
        check("up10_led", 32'(o_LED_Toggle), 32'd0);

        // Preload 99, wrap up to 00, wrap down to 99
        do_reset();
        check("rst2_count", 32'({o_Tens, o_Ones}), 32'h00);
        sc = step_count;
        for (int i = 0; i < 99; i++) man(1'b1);
        wait_steps(sc + 99, 20);
        check("preload_99", 32'({o_Tens, o_Ones}), 32'h99);
        man(1'b1);
        man(1'b0);
        wait_steps(sc + 101, 20);
        check("wrap_down_99", 32'({o_Tens, o_Ones}), 32'h99);
        check("wrap_led", 32'(o_LED_Toggle), 32'(exp_led));

        // Move to 05 then run auto-up at an 8-clock period
        for (int i = 0; i < 6; i++) man(1'b1);
        wait_steps(sc + 107, 20);
        check("at_05", 32'({o_Tens, o_Ones}), 32'h05);
        i_Auto_Dir = 1'b1;
        i_Auto_En  = 1'b1;
        @(posedge clk); #2;
        c0 = cyc;
        check("auto_active", 32'(o_Auto_Active), 32'd1);
        base = step_cycs.size();
        for (int i = 0; i < 3; i++) push_step(1'b1);
        wait_steps(step_count + 3, 40);
        check("auto_cyc0", 32'(step_cyc_at(base)), 32'(c0 + 8));
        check("auto_cyc1", 32'(step_cyc_at(base + 1)), 32'(c0 + 16));
        check("auto_cyc2", 32'(step_cyc_at(base + 2)), 32'(c0 + 24));
        check("auto_at_08", 32'({o_Tens, o_Ones}), 32'h08);
        i_Auto_En = 1'b0;

        // Up and Down together cancel at 42
        sc = step_count;
        for (int i = 0; i < 34; i++) man(1'b1);
        wait_steps(sc + 34, 20);
        check("idle_after_disable", 32'(o_Auto_Active), 32'd0);
        sc = step_count;
        pulse(1'b1, 1'b1);
        @(posedge clk); #2;
        check("cancel_no_step", 32'(step_count), 32'(sc));
        check("cancel_count", 32'({o_Tens, o_Ones}), 32'h42);
        check("cancel_led", 32'(o_LED_Toggle), 32'(exp_led));

        // Manual Down coincident with a tick at 20, then holdoff of two ticks
        for (int i = 0; i < 22; i++) man(1'b0);
        wait_steps(sc + 22, 20);
        check("at_20", 32'({o_Tens, o_Ones}), 32'h20);
        i_Auto_Dir = 1'b1;
        i_Auto_En  = 1'b1;
        @(posedge clk); #2;
        c0 = cyc;
        base = step_cycs.size();
        repeat (7) @(posedge clk);
        #2;
        man(1'b0);
        push_step(1'b1);
        check("hold_after_manual", 32'(o_Auto_Active), 32'd0);
        check("manual_cyc", 32'(step_cyc_at(base)), 32'(c0 + 8));
        repeat (15) @(posedge clk);
        #2;
        check("still_hold", 32'(o_Auto_Active), 32'd0);
        @(posedge clk); #2;
        check("back_to_run", 32'(o_Auto_Active), 32'd1);
        wait_steps(sc + 24, 20);
        check("resume_cyc", 32'(step_cyc_at(base + 1)), 32'(c0 + 32));
        check("resume_at_20", 32'({o_Tens, o_Ones}), 32'h20);

        // Async reset mid-holdoff at 37
        for (int i = 0; i < 17; i++) man(1'b1);
        wait_steps(sc + 41, 20);
        check("at_37", 32'({o_Tens, o_Ones}), 32'h37);
        check("hold_at_37", 32'(o_Auto_Active), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        i_Rst_L = 1'b0;
        #1;
        check("async_count", 32'({o_Tens, o_Ones}), 32'h00);
        check("async_auto", 32'(o_Auto_Active), 32'd0);
        check("async_led", 32'(o_LED_Toggle), 32'd0);
        @(posedge clk); #2;
        i_Rst_L = 1'b1;
        exp_val = 0;
        exp_led = 1'b0;
        @(posedge clk); #2;
        c0 = cyc;
        check("run_after_reset", 32'(o_Auto_Active), 32'd1);
        base = step_cycs.size();
        push_step(1'b1);
        wait_steps(sc + 42, 20);
        check("first_auto_cyc", 32'(step_cyc_at(base)), 32'(c0 + 8));
        check("first_auto_01", 32'({o_Tens, o_Ones}), 32'h01);
        i_Auto_En = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_count_sequencer.md
Name: bcd_count_sequencer

Overview:
Owns the two-digit decimal count (00-99) that drives the tens and ones seven-segment decoders on the Go Board. It arbitrates between manual up/down requests from the debounced switch edge detectors and a free-running auto-step timer, and keeps the count in BCD so each digit feeds its own Binary_To_7Segment instance directly. Manual input pauses auto-stepping for a programmable holdoff, after which auto-stepping resumes.

Parameters:
TICK_PERIOD, 500000, clocks between auto steps (>=2)
HOLDOFF_TICKS, 4, auto periods to suppress auto-stepping after a manual step (>=1)
CNT_W, 32, width of the tick timer (must hold TICK_PERIOD-1)

Ports:
i_Clk  in  1  system clock (25 MHz)
i_Rst_L  in  1  asynchronous active-low reset
i_Up  in  1  single-cycle manual increment request
i_Down  in  1  single-cycle manual decrement request
i_Auto_En  in  1  level; 1 enables auto-stepping
i_Auto_Dir  in  1  level; 1 = auto counts up, 0 = down
o_Tens  out  4  BCD tens digit, 0-9
o_Ones  out  4  BCD ones digit, 0-9
o_Step  out  1  one-cycle pulse on any count change
o_Wrap  out  1  one-cycle pulse when the count wraps 99->00 or 00->99
o_Auto_Active  out  1  1 while in S_RUN
o_LED_Toggle  out  1  toggles on every manual step

Behaviour:
- Clock and reset: one clock, i_Clk; reset is asynchronous, active-low, on i_Rst_L.
- Reset values (async, immediate): o_Tens=0, o_Ones=0, o_Step=0, o_Wrap=0, o_LED_Toggle=0, timer=0, holdoff=0, state=S_IDLE, so o_Auto_Active=0.
- Outputs are registered. A count change is visible on o_Tens/o_Ones one clock after the requesting cycle. o_Step and o_Wrap assert in that same cycle.
- Tick timer:
  - Counts 0..TICK_PERIOD-1, then wraps to 0.
  - tick=1 in the cycle the timer equals TICK_PERIOD-1, giving exactly one tick per TICK_PERIOD clocks.
  - The timer clears to 0 on any accepted manual step and whenever state is S_IDLE.
- State machine:
  - S_IDLE: auto disabled. Go to S_RUN when i_Auto_En=1 and holdoff=0. Go to S_HOLD when i_Auto_En=1 and holdoff>0.
  - S_RUN: each tick steps the count in the i_Auto_Dir direction. An accepted manual step loads holdoff=HOLDOFF_TICKS and goes to S_HOLD. i_Auto_En=0 goes to S_IDLE.
  - S_HOLD: each tick decrements holdoff with no count change. When holdoff reaches 0, go to S_RUN on the following cycle. Another manual step reloads holdoff. i_Auto_En=0 goes to S_IDLE and clears holdoff.
- Manual steps are accepted in every state, including S_IDLE.
- Arbitration within one cycle, priority high to low:
  1. i_Up and i_Down both high: they cancel. No step, no toggle, no holdoff reload, timer not cleared.
  2. Exactly one manual request: the manual step wins. A coincident auto tick is dropped, not deferred.
  3. Auto tick in S_RUN.
- BCD arithmetic:
  - Increment: ones 9 -> 0 with carry into tens; tens 9 with carry -> 0 and asserts o_Wrap.
  - Decrement: ones 0 -> 9 with borrow from tens; tens 0 with borrow -> 9 and asserts o_Wrap.
  - Digits never take values 10-15.
- o_LED_Toggle inverts on every accepted manual step. It does not change on auto steps.
- A reset mid-holdoff or mid-period discards all state; there is no resume.

Decomposition:
- Package bcd_count_pkg holds:
  - state encoding S_IDLE=2'd0, S_RUN=2'd1, S_HOLD=2'd2;
  - BCD_MAX=4'd9.
- One sub-module, bcd_digit_step. It is combinational: inputs digit, up/down, carry-in; outputs next digit and carry-out. It is instanced twice, ones feeding tens.
- The top level holds the timer, FSM, arbitration and output registers.

Test Plan:
- Reset then 10 i_Up pulses from 00 -> count 10, o_Step pulses 10 times, o_Wrap never asserts, o_LED_Toggle ends at 0.
- Preload 99 via 99 i_Up pulses, then one more i_Up -> count 00 with o_Wrap=1 for exactly one cycle; then i_Down -> count 99 with o_Wrap=1.
- i_Auto_En=1, i_Auto_Dir=1, TICK_PERIOD=8, from 05 -> count 06,07,08 at 8-clock spacing; o_Auto_Active=1.
- i_Up and i_Down high together at count 42 -> count stays 42, no o_Step, o_LED_Toggle unchanged.
- Auto running with TICK_PERIOD=8 and HOLDOFF_TICKS=2; manual i_Down coincident with a tick at 20 -> count 19 (tick dropped); no auto step for 2 ticks; state S_HOLD, then S_RUN; the next auto step lands at 20.
- Drop i_Rst_L asynchronously mid-period at count 37 in S_HOLD -> outputs read 00, o_Auto_Active=0 before the next clock edge; after release with i_Auto_En=1, the first auto step occurs TICK_PERIOD clocks after entering S_RUN.
